conv_relu_pool_engine: RTL

//  Parametrised successor of the fixed 64x64 convolution layer: a runtime-programmable 3x3 conv, zero-padded, stride 1.

---
 rtl/conv_relu_pool_engine.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_relu_pool_engine.sv
// Runtime-programmable 3x3 zero-padded convolution with round/saturate and optional ReLU
// into layer-0 RAM, followed by an optional 2x2/stride-2 max-pool pass into layer-1 RAM.
module conv_relu_pool_engine #(
    parameter int IMG_LOG2 = 6,
    parameter int DATA_W   = 20,
    parameter int FRAC_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     ready_i,
    output logic                     busy_o,
    input  logic                     pool_en_i,
    input  logic                     relu_en_i,
    input  logic                     cfg_we_i,
    input  logic [3:0]               cfg_addr_i,
    input  logic signed [DATA_W-1:0] cfg_data_i,
    output logic [2*IMG_LOG2-1:0]    iaddr_o,
    input  logic signed [DATA_W-1:0] idata_i,
    output logic                     cwr_o,
    output logic [2*IMG_LOG2-1:0]    caddr_wr_o,
    output logic signed [DATA_W-1:0] cdata_wr_o,
    output logic                     crd_o,
    output logic [2*IMG_LOG2-1:0]    caddr_rd_o,
    input  logic signed [DATA_W-1:0] cdata_rd_i,
    output logic [2:0]               csel_o
);
    localparam int L     = IMG_LOG2;
    localparam int AW    = 2 * IMG_LOG2;
    localparam int PW    = IMG_LOG2 + 2;
    localparam int ACC_W = 2 * DATA_W + 4;
    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] HALF    = ONE <<< (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ONE <<< (DATA_W - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ONE <<< (DATA_W - 1));
    localparam logic signed [19:0] W_RST [9] = '{20'sh0A89E, 20'sh092D5, 20'sh06D43,
                                                 20'sh01004, 20'shF8F71, 20'shF6E54,
                                                 20'shFA6D7, 20'shFC834, 20'shFAC19};
    localparam logic signed [19:0] B_RST = 20'sh01310;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE0, POOL, DONE} state_e;

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] w_q [9];
    logic signed [DATA_W-1:0] bias_q;
    logic                     pool_q, relu_q;
    logic [L-1:0]             row_q, col_q;
    logic [1:0]               dy_q, dx_q;
    logic [3:0]               tap_q, prev_tap_q;
    logic                     prev_valid_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [L-2:0]             pr_q, pc_q;
    logic [2:0]               ph_q;
    logic signed [DATA_W-1:0] max_q;
    logic [AW-1:0]            iaddr_q, iaddr_d;
    logic [AW-1:0]            caddr_wr_q, caddr_wr_d;
    logic [AW-1:0]            caddr_rd_q, caddr_rd_d;
    logic signed [DATA_W-1:0] cdata_wr_q, cdata_wr_d;

    logic [PW-1:0]              tap_row, tap_col;
    logic                       tap_valid;
    logic [AW-1:0]              tap_addr;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    rounded, scaled;
    logic signed [DATA_W-1:0]   conv_res;
    logic                       last_tap, last_pixel, last_pool;

    // Neighbour coordinates carry two guard bits: -1 wraps to 11.., W sets bit L.
    assign tap_row   = {2'b00, row_q} + {{L{1'b0}}, dy_q} - PW'(1);
    assign tap_col   = {2'b00, col_q} + {{L{1'b0}}, dx_q} - PW'(1);
    assign tap_valid = (tap_row[PW-1:L] == 2'b00) && (tap_col[PW-1:L] == 2'b00);
    assign tap_addr  = {tap_row[L-1:0], tap_col[L-1:0]};

    assign prod       = w_q[prev_tap_q] * idata_i;
    assign last_tap   = (tap_q == 4'd8);
    assign last_pixel = (&row_q) && (&col_q);
    assign last_pool  = (&pr_q) && (&pc_q);

    always_comb begin
        rounded = acc_q + (ACC_W'(bias_q) <<< FRAC_W) + HALF;
        scaled  = rounded >>> FRAC_W;
        if (scaled > SAT_MAX) begin
            conv_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (scaled < SAT_MIN) begin
            conv_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            conv_res = scaled[DATA_W-1:0];
        end
        if (relu_q && conv_res[DATA_W-1]) begin
            conv_res = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ready_i) state_d = FETCH;
            FETCH:   if (last_tap) state_d = DRAIN;
            DRAIN:   state_d = WRITE0;
            WRITE0:  if (last_pixel) state_d = pool_q ? POOL : DONE;
                     else state_d = FETCH;
            POOL:    if (ph_q == 3'd5 && last_pool) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/data outputs hold their last driven value outside the cycles that own them.
    always_comb begin
        busy_o     = (state_q != IDLE);
        cwr_o      = 1'b0;
        crd_o      = 1'b0;
        csel_o     = 3'd0;
        iaddr_d    = iaddr_q;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        case (state_q)
            FETCH: begin
                if (tap_valid) iaddr_d = tap_addr;
            end
            WRITE0: begin
                cwr_o      = 1'b1;
                csel_o     = 3'd1;
                caddr_wr_d = {row_q, col_q};
                cdata_wr_d = conv_res;
            end
            POOL: begin
                csel_o = 3'd1;
                if (ph_q < 3'd4) begin
                    crd_o      = 1'b1;
                    caddr_rd_d = {pr_q, ph_q[1], pc_q, ph_q[0]};
                end else if (ph_q == 3'd5) begin
                    cwr_o      = 1'b1;
                    csel_o     = 3'd3;
                    caddr_wr_d = {2'b00, pr_q, pc_q};
                    cdata_wr_d = max_q;
                end
            end
            default: ;
        endcase
    end

    assign iaddr_o    = iaddr_d;
    assign caddr_wr_o = caddr_wr_d;
    assign caddr_rd_o = caddr_rd_d;
    assign cdata_wr_o = cdata_wr_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 9; i++) w_q[i] <= DATA_W'(W_RST[i]);
            bias_q       <= DATA_W'(B_RST);
            pool_q       <= 1'b0;
            relu_q       <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            dy_q         <= '0;
            dx_q         <= '0;
            tap_q        <= '0;
            prev_tap_q   <= '0;
            prev_valid_q <= 1'b0;
            acc_q        <= '0;
            pr_q         <= '0;
            pc_q         <= '0;
            ph_q         <= '0;
            max_q        <= '0;
            iaddr_q      <= '0;
            caddr_wr_q   <= '0;
            caddr_rd_q   <= '0;
            cdata_wr_q   <= '0;
        end else begin
            iaddr_q      <= iaddr_d;
            caddr_wr_q   <= caddr_wr_d;
            caddr_rd_q   <= caddr_rd_d;
            cdata_wr_q   <= cdata_wr_d;
            prev_valid_q <= (state_q == FETCH) && tap_valid;
            prev_tap_q   <= tap_q;
            if (prev_valid_q) acc_q <= acc_q + ACC_W'(prod);
            case (state_q)
                IDLE: begin
                    if (cfg_we_i) begin
                        if (cfg_addr_i < 4'd9) w_q[cfg_addr_i] <= cfg_data_i;
                        else if (cfg_addr_i == 4'd9) bias_q <= cfg_data_i;
                    end
                    if (ready_i) begin
                        pool_q <= pool_en_i;
                        relu_q <= relu_en_i;
                        row_q  <= '0;
                        col_q  <= '0;
                        dy_q   <= '0;
                        dx_q   <= '0;
                        tap_q  <= '0;
                        acc_q  <= '0;
                    end
                end
                FETCH: begin
                    tap_q <= tap_q + 4'd1;
                    if (dx_q == 2'd2) begin
                        dx_q <= '0;
                        dy_q <= dy_q + 2'd1;
                    end else begin
                        dx_q <= dx_q + 2'd1;
                    end
                end
                WRITE0: begin
                    acc_q <= '0;
                    tap_q <= '0;
                    dx_q  <= '0;
                    dy_q  <= '0;
                    col_q <= col_q + 1'b1;
                    if (&col_q) row_q <= row_q + 1'b1;
                    ph_q  <= '0;
                    pr_q  <= '0;
                    pc_q  <= '0;
                end
                POOL: begin
                    // Read data lags the address by one cycle, so phases 1..4 see the four reads.
                    if (ph_q == 3'd1) begin
                        max_q <= cdata_rd_i;
                    end else if (ph_q >= 3'd2 && ph_q <= 3'd4 && cdata_rd_i > max_q) begin
                        max_q <= cdata_rd_i;
                    end
                    if (ph_q == 3'd5) begin
                        ph_q <= '0;
                        pc_q <= pc_q + 1'b1;
                        if (&pc_q) pr_q <= pr_q + 1'b1;
                    end else begin
                        ph_q <= ph_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
